// File: rtl/telemetry_tx.sv
// telemetry_tx: 8N1 UART sender of an 11-byte frame (start, height/pitch/roll/yaw, XOR checksum, stop)
module telemetry_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200,
  parameter logic [7:0] START_BYTE = 8'hAA,
  parameter logic [7:0] STOP_BYTE = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [15:0] height,
  input  logic [15:0] pitch,
  input  logic [15:0] roll,
  input  logic [15:0] yaw,
  output logic        TxD,
  output logic        busy,
  output logic        done,
  output logic        send_dropped
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [3:0] byte_idx_q, byte_idx_d;
  logic [63:0] payload_q, payload_d;
  logic [7:0] csum_q, csum_d;
  logic txd_q, txd_d, busy_q, busy_d, done_q, done_d, drop_q, drop_d;
  logic [7:0] pay_byte, cur_byte;
  logic bit_end;
  assign pay_byte = 8'(payload_q >> {4'd8 - byte_idx_q, 3'b000});
  assign cur_byte = byte_idx_q == 4'd0 ? START_BYTE :
                    byte_idx_q == 4'd9 ? csum_q :
                    byte_idx_q == 4'd10 ? STOP_BYTE : pay_byte;
  assign bit_end = cnt_q == CNT_MAX;
  always_comb begin
    state_d = state_q;
    bit_idx_d = bit_idx_q;
    byte_idx_d = byte_idx_q;
    payload_d = payload_q;
    csum_d = csum_q;
    txd_d = txd_q;
    busy_d = busy_q;
    done_d = 1'b0;
    drop_d = send & busy_q;
    cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (send) begin
        state_d = START;
        payload_d = {height, pitch, roll, yaw};
        csum_d = height[15:8] ^ height[7:0] ^ pitch[15:8] ^ pitch[7:0] ^
                 roll[15:8] ^ roll[7:0] ^ yaw[15:8] ^ yaw[7:0];
        byte_idx_d = 4'd0;
        txd_d = 1'b0;
        busy_d = 1'b1;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_idx_d = 3'd0;
        txd_d = cur_byte[0];
      end
      DATA: if (bit_end) begin
        if (bit_idx_q == 3'd7) begin
          state_d = STOP;
          txd_d = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          txd_d = cur_byte[bit_idx_q + 3'd1];
        end
      end
      STOP: if (bit_end) begin
        if (byte_idx_q == 4'd10) begin
          state_d = IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
          txd_d = 1'b1;
        end else begin
          state_d = START;
          byte_idx_d = byte_idx_q + 4'd1;
          txd_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_idx_q <= '0;
      byte_idx_q <= '0;
      payload_q <= '0;
      csum_q <= '0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_idx_q <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      payload_q <= payload_d;
      csum_q <= csum_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end
  assign TxD = txd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign send_dropped = drop_q;
endmodule

// File: doc/telemetry_tx.md
Name: telemetry_tx

Overview:
- UART transmitter that sends the flight controller's current height, pitch, roll and yaw to the ground station.
- Mirrors the command receiver on the same serial link: same 8N1 framing, baud rate, start byte 0xAA and stop byte 0x55.
- On a send strobe it snapshots four 16-bit values and sends one 11-byte frame: start byte, 8 payload bytes, XOR checksum, stop byte.
- It contains its own baud generator and serializer, and sits beside the command receiver at the top level.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- START_BYTE, 8'hAA, frame header byte.
- STOP_BYTE, 8'h55, frame trailer byte.
- Derived constant DIV = (CLK_FREQ + BAUD/2) / BAUD, the clocks per bit (434 at the defaults). DIV must be at least 2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- send, input, 1, request to transmit one frame; level-sampled every clock.
- height, input, 16, height value to report.
- pitch, input, 16, pitch value (signed, two's complement).
- roll, input, 16, roll value (signed).
- yaw, input, 16, yaw value (signed).
- TxD, output, 1, serial line; idles high.
- busy, output, 1, high while a frame is in progress.
- done, output, 1, one-cycle pulse when a frame completes.
- send_dropped, output, 1, one-cycle pulse when send is asserted while busy.

Behaviour:
- Reset values: TxD=1, busy=0, done=0, send_dropped=0, state=IDLE, all counters 0.
- Reset is asynchronous, so TxD returns high immediately, including mid-frame. Any partly sent frame is abandoned; there is no resume.
- Clock edge naming: the edge that samples send high is "edge N"; "cycle N+1" is the clock period right after it.
- State machine: IDLE -> START -> DATA -> STOP, then either START (next byte) or IDLE (after the last byte).
- IDLE:
  - TxD=1, busy=0.
  - send=1 at edge N: latch height, pitch, roll and yaw into a payload shadow register, compute the checksum, set byte_idx=0, go to START.
  - From cycle N+1: busy=1 and TxD=0.
- START: TxD=0 for DIV clocks, then go to DATA with bit_idx=0.
- DATA:
  - TxD = current byte[bit_idx], LSB first, each bit held DIV clocks.
  - After bit 7, go to STOP.
- STOP:
  - TxD=1 for DIV clocks.
  - Then, if byte_idx=10, go to IDLE; otherwise increment byte_idx and go to START.
  - There is no idle gap between bytes.
- Byte order by byte_idx:
  - 0: START_BYTE.
  - 1-2: height[15:8], height[7:0].
  - 3-4: pitch high byte, pitch low byte.
  - 5-6: roll high byte, roll low byte.
  - 7-8: yaw high byte, yaw low byte.
  - 9: checksum, the XOR of bytes 1-8.
  - 10: STOP_BYTE.
- Frame length is exactly 110*DIV clocks: TxD goes low in cycle N+1 and the last stop bit ends at cycle N+110*DIV.
- Frame completion: in cycle N+1+110*DIV the block is back in IDLE, busy=0 and done=1 for exactly one cycle.
- Back-to-back frames: send=1 sampled during the done cycle is accepted. busy rises again on the next cycle and the next start bit follows with no extra idle time.
- Snapshot: changes on the value inputs after edge N do not affect the frame being sent.
- send_dropped: send=1 sampled while busy=1 gives a one-cycle send_dropped pulse on the next cycle. The current frame is unchanged and the request is not queued.
- Baud counter: counts 0..DIV-1 and reloads at every bit boundary. It is held at 0 in IDLE, so the first bit is always exactly DIV clocks long.
- Implementation limits: the baud counter is wide enough for DIV-1, bit_idx is 3 bits, byte_idx is 4 bits.

Test Plan:
- Frame content (sim with CLK_FREQ=1000, BAUD=100, so DIV=10): height=16'h1234, pitch=16'hFE0C (-500), roll=16'h01F4, yaw=0, pulse send -> decoded bytes are AA 12 34 FE 0C 01 F4 00 00 21 55, each framed 8N1, LSB first.
- Timing (same parameters): send at edge N -> TxD=0 from cycle N+1; every bit exactly 10 clocks; busy high for 1100 cycles; done pulses once at cycle N+1101 with busy=0.
- Ignored requests: pulse send again at bit 40, with all value inputs changed -> send_dropped pulses once; the transmitted frame still matches the first scenario; exactly one done pulse.
- Back-to-back: hold send=1 continuously -> frames follow with no idle bits between them; done pulses every 1100 cycles; send_dropped fires every busy cycle.
- Reset mid-frame: assert rst_n=0 during a data bit of byte 5 -> TxD=1, busy=0 and done=0 immediately. After release, send with all inputs zero -> frame AA 00 00 00 00 00 00 00 00 00 55.
- Default parameters: DIV=434; a full frame takes 47740 clocks; a receiver model running at 115200 baud decodes every byte correctly.
